// File: rtl/half_word_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : half_word_packer_pkg
// Brief    : Shared widths and state encoding for the half-word packer.
// Revision : 1.0 - initial release
// ============================================================================
package half_word_packer_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HALF = 2'b01,
    FULL = 2'b10
  } state_t;

endpackage : half_word_packer_pkg
`default_nettype wire

// File: rtl/half_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : half_word_packer
// Brief    : Packs two 16-bit half-words into one 32-bit word on valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module half_word_packer
  import half_word_packer_pkg::*;
#(
  parameter int HI_FIRST = 0,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HALF_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_bit0,
  output logic [HALF_W-1:0] out_hi,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              drop_err
);

  state_t              r_state;
  logic [HALF_W-1:0]   r_partial;
  logic [WORD_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic [CNT_W-1:0]    r_word_cnt;
  logic                r_drop_err;

  logic                w_in_ready;
  logic                w_accept;
  logic [WORD_W-1:0]   w_pack;

  // A held word can only be replaced in the same cycle it drains.
  assign w_in_ready = !flush && ((r_state != FULL) || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  generate
    if (HI_FIRST != 0) begin : g_hi_first
      assign w_pack = {r_partial, in_data};
    end else begin : g_lo_first
      assign w_pack = {in_data, r_partial};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_partial   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_word_cnt  <= '0;
      r_drop_err  <= 1'b0;
    end else begin
      r_drop_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_partial <= in_data;
            r_state   <= HALF;
          end
        end
        HALF: begin
          if (flush) begin
            r_partial  <= '0;
            r_drop_err <= 1'b1;
            r_state    <= IDLE;
          end else if (w_accept) begin
            r_out_data  <= w_pack;
            r_out_valid <= 1'b1;
            r_state     <= FULL;
          end
        end
        FULL: begin
          if (out_ready) begin
            r_word_cnt  <= r_word_cnt + CNT_W'(1);
            r_out_valid <= 1'b0;
            if (w_accept) begin
              r_partial <= in_data;
              r_state   <= HALF;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_bit0  = r_out_data[0];
  assign out_hi    = r_out_data[WORD_W-1:HALF_W];
  assign word_cnt  = r_word_cnt;
  assign drop_err  = r_drop_err;

endmodule : half_word_packer
`default_nettype wire

// File: tb/tb_half_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_half_word_packer
// Brief    : Scoreboard bench driving a low-first/8-bit and a high-first/4-bit packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_half_word_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready0, out_valid0, out_bit00, drop_err0;
  logic [31:0] out_data0;
  logic [15:0] out_hi0;
  logic [7:0]  word_cnt0;
  logic        in_ready1, out_valid1, out_bit01, drop_err1;
  logic [31:0] out_data1;
  logic [15:0] out_hi1;
  logic [3:0]  word_cnt1;

  always #5 clk = ~clk;

  half_word_packer #(.HI_FIRST(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_bit0(out_bit00), .out_hi(out_hi0),
    .word_cnt(word_cnt0), .drop_err(drop_err0));

  half_word_packer #(.HI_FIRST(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_bit0(out_bit01), .out_hi(out_hi1),
    .word_cnt(word_cnt1), .drop_err(drop_err1));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a pending half (if any), a held word (if any), delivered count.
  logic        m_half_held = 1'b0;
  logic [15:0] m_half      = '0;
  logic        m_word      = 1'b0;
  logic [31:0] m_last0     = '0;
  logic [31:0] m_last1     = '0;
  int          m_cnt       = 0;
  logic        m_drop      = 1'b0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_regs();
    chk("out_valid0", 32'(out_valid0), 32'(m_word));
    chk("out_valid1", 32'(out_valid1), 32'(m_word));
    chk("out_data0", out_data0, m_last0);
    chk("out_data1", out_data1, m_last1);
    chk("out_bit0_0", 32'(out_bit00), 32'(m_last0[0]));
    chk("out_bit0_1", 32'(out_bit01), 32'(m_last1[0]));
    chk("out_hi0", 32'(out_hi0), 32'(m_last0[31:16]));
    chk("out_hi1", 32'(out_hi1), 32'(m_last1[31:16]));
    chk("word_cnt0", 32'(word_cnt0), 32'(m_cnt % 256));
    chk("word_cnt1", 32'(word_cnt1), 32'(m_cnt % 16));
    chk("drop_err0", 32'(drop_err0), 32'(m_drop));
    chk("drop_err1", 32'(drop_err1), 32'(m_drop));
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic f, input logic r);
    logic exp_rdy, acc, xfer;
    in_valid = v; in_data = d; flush = f; out_ready = r;
    #1;
    exp_rdy = !f && (!m_word || r);
    chk("in_ready0", 32'(in_ready0), 32'(exp_rdy));
    chk("in_ready1", 32'(in_ready1), 32'(exp_rdy));
    acc  = v && exp_rdy;
    xfer = m_word && r;
    @(posedge clk);
    m_drop = 1'b0;
    if (xfer) begin
      m_word = 1'b0;
      m_cnt++;
    end
    if (f && m_half_held) begin
      m_half_held = 1'b0;
      m_drop      = 1'b1;
    end else if (acc) begin
      if (m_half_held) begin
        m_last0 = {d, m_half};
        m_last1 = {m_half, d};
        q0.push_back(m_last0);
        q1.push_back(m_last1);
        m_word      = 1'b1;
        m_half_held = 1'b0;
      end else begin
        m_half      = d;
        m_half_held = 1'b1;
      end
    end
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    m_half_held = 1'b0; m_half = '0; m_word = 1'b0; m_last0 = '0; m_last1 = '0;
    m_cnt = 0; m_drop = 1'b0;
    q0.delete(); q1.delete();
    check_regs();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: a word transfers whenever valid and ready meet at a clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid0 && out_ready) begin
        if (q0.size() == 0) chk("sb0_unexpected", out_data0, 32'hxxxx_xxxx);
        else chk("sb0_word", out_data0, q0.pop_front());
      end
      if (rst_n && out_valid1 && out_ready) begin
        if (q1.size() == 0) chk("sb1_unexpected", out_data1, 32'hxxxx_xxxx);
        else chk("sb1_word", out_data1, q1.pop_front());
      end
    end
  end

  initial begin
    #2;
    check_regs();
    do_reset();

    // Pack, low half first
    step(1, 16'h4321, 0, 1);
    step(1, 16'h8765, 0, 1);
    chk("pack_valid", 32'(out_valid0), 32'd1);
    chk("pack_data", out_data0, 32'h8765_4321);
    chk("pack_bit0", 32'(out_bit00), 32'd1);
    chk("pack_hi", 32'(out_hi0), 32'h0000_8765);
    step(0, 16'h0, 0, 1);
    chk("pack_cnt", 32'(word_cnt0), 32'd1);

    // Backpressure with DEADBEEF held
    step(1, 16'hBEEF, 0, 0);
    step(1, 16'hDEAD, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 16'h1111, 0, 0);
    chk("bp_data", out_data0, 32'hDEAD_BEEF);
    chk("bp_cnt", 32'(word_cnt0), 32'd1);
    step(1, 16'h1111, 0, 1);
    chk("bp_cnt_after", 32'(word_cnt0), 32'd2);
    step(1, 16'h2222, 0, 1);
    chk("bp_next", out_data0, 32'h2222_1111);
    step(0, 16'h0, 0, 1);

    // Streaming
    for (int i = 1; i <= 8; i++) step(1, 16'(i), 0, 1);
    step(0, 16'h0, 0, 1);
    chk("stream_cnt", 32'(word_cnt0), 32'd7);
    chk("stream_last", out_data0, 32'h0008_0007);

    // Flush of a partial word, then flush in IDLE
    step(1, 16'hAAAA, 0, 1);
    step(0, 16'h0, 1, 1);
    chk("flush_drop", 32'(drop_err0), 32'd1);
    step(0, 16'h0, 1, 1);
    chk("flush_idle_drop", 32'(drop_err0), 32'd0);
    step(1, 16'h0002, 0, 1);
    step(1, 16'h0001, 0, 1);
    chk("flush_word", out_data0, 32'h0001_0002);
    // Flush while FULL keeps the word and blocks input
    step(1, 16'h5555, 1, 0);
    step(0, 16'h0, 0, 1);

    // Counter wrap on the 4-bit instance, then high-first ordering
    do_reset();
    for (int i = 0; i < 32; i++) step(1, 16'(i * 3 + 1), 0, 1);
    step(0, 16'h0, 0, 1);
    chk("wrap_cnt1", 32'(word_cnt1), 32'd0);
    chk("wrap_cnt0", 32'(word_cnt0), 32'd16);
    step(1, 16'h8765, 0, 1);
    step(1, 16'h4321, 0, 1);
    chk("order_hi", out_data1, 32'h8765_4321);
    chk("order_lo", out_data0, 32'h4321_8765);
    step(0, 16'h0, 0, 1);

    // Reset in HALF, then in FULL
    step(1, 16'h1234, 0, 1);
    do_reset();
    step(0, 16'h0, 0, 0);
    step(1, 16'h1234, 0, 0);
    step(1, 16'h5678, 0, 0);
    do_reset();
    step(0, 16'h0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), 16'($urandom), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 6));
    end
    for (int i = 0; i < 4; i++) step(0, 16'h0, 0, 1);
    chk("sb0_drained", 32'(q0.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_half_word_packer
`default_nettype wire
